stride_write_controller: RTL



---
 rtl/stride_write_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/stride_write_controller.sv
// Writer side of the stride buffer: streams words into the circular buffer, publishes
// each stride's end address and waits for the reader. Optional macro: STRIDE_LEN_OUT_EN.
module stride_write_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  input  logic                  stride_done_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0] end_ptr_o,
  output logic                  ep_valid_o,
  output logic                  stride_trunc_o,
`ifdef STRIDE_LEN_OUT_EN
  output logic [ADDR_WIDTH-1:0] stride_len_o,
`endif
  output logic                  dbg_state_o
);

  // Handshake: a word moves when in_valid_i & in_ready_o are both high at a rising
  // clk_i edge; in_valid_i may be held across PUBLISH and the word is taken later.
  typedef enum logic {FILL = 1'b0, PUBLISH = 1'b1} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_d;
  logic [ADDR_WIDTH-1:0] end_ptr_q;
  logic                  ep_valid_q;
  logic                  trunc_q;
  logic                  accept;
  logic                  full_hit;
  logic                  close;

  assign in_ready_o = ~rst_i & (state_q == FILL);
  assign accept     = in_valid_i & in_ready_o;
  assign wr_ptr_d   = wr_ptr_q + ADDR_ONE;

  // The reader sits parked at the stride start, so a stride holds at most D-1 words:
  // the word at A is the last one that fits when A+2 lands on the reader.
  assign full_hit   = (wr_ptr_q + ADDR_TWO) == read_addr_i;
  assign close      = accept & (in_last_i | full_hit);

  assign wr_en_o        = accept;
  assign wr_addr_o      = wr_ptr_q;
  assign wr_data_o      = in_data_i;
  assign end_ptr_o      = end_ptr_q;
  assign ep_valid_o     = ep_valid_q;
  assign stride_trunc_o = trunc_q;
  assign dbg_state_o    = state_q;

`ifdef STRIDE_LEN_OUT_EN
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] len_q;

  assign stride_len_o = len_q;

  // cnt_q counts words already accepted in the open stride.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (accept) begin
      if (close) begin
        cnt_q <= '0;
        len_q <= cnt_q + ADDR_ONE;
      end else begin
        cnt_q <= cnt_q + ADDR_ONE;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      end_ptr_q  <= '0;
      ep_valid_q <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_d;
          end
          if (close) begin
            end_ptr_q  <= wr_ptr_q;
            ep_valid_q <= 1'b1;
            trunc_q    <= ~in_last_i;
            state_q    <= PUBLISH;
          end
        end
        PUBLISH: begin
          if (stride_done_i) begin
            ep_valid_q <= 1'b0;
            trunc_q    <= 1'b0;
            state_q    <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
